// File: rtl/encode_out.sv
// Packs variable-width codes MSB-first into 64-bit words, with a single-entry
// pending register in front of the output FIFO and a flush path for the final word.
module encode_out #(
    parameter int IN_WIDTH       = 13,
    parameter int NEED_STR_WIDTH = 4,
    parameter int LZF_WIDTH      = 20
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [IN_WIDTH-1:0]       code_data,
    input  logic [NEED_STR_WIDTH-1:0] code_width,
    input  logic                      code_valid,
    output logic                      code_ack,
    input  logic                      flush,
    input  logic                      fo_full,
    output logic [63:0]               fo_data,
    output logic                      fo_wen,
    output logic                      fo_last,
    output logic [LZF_WIDTH-1:0]      fo_cnt,
    output logic                      all_end
);

    typedef enum logic [1:0] {S_RUN, S_FLUSH, S_DONE} state_t;

    state_t       state, state_next;
    logic [63:0]  acc;
    logic [5:0]   bitcnt;
    logic [63:0]  pend_data;
    logic         pend_valid;
    logic         pend_last;

    logic         width_ok;
    logic [6:0]   sum;
    logic [7:0]   shift_amt;
    logic [127:0] code_mask;
    logic [127:0] code_ext;
    logic [127:0] merged;
    logic         flush_load;

    assign fo_wen   = pend_valid & ~fo_full;
    assign fo_data  = pend_data;
    assign fo_last  = pend_last & fo_wen;
    // Gated by rst so a held code_valid cannot be acknowledged while in reset.
    assign code_ack = rst & code_valid & (state == S_RUN) & (~pend_valid | ~fo_full);
    assign all_end  = (state == S_DONE);

    assign width_ok  = (code_width != '0) && (int'(code_width) <= IN_WIDTH);
    assign sum       = 7'(bitcnt) + 7'(code_width);
    assign shift_amt = 8'd128 - 8'(sum);
    assign code_mask = (128'd1 << code_width) - 128'd1;
    assign code_ext  = 128'(code_data) & code_mask;
    // Upper half is the word being built; any overflow lands in the lower half.
    assign merged    = {acc, 64'd0} | (code_ext << shift_amt);

    assign flush_load = (state == S_FLUSH) && !pend_valid && (bitcnt != 6'd0);

    always_comb begin
        state_next = state;
        case (state)
            S_RUN: begin
                if (flush && !code_valid)
                    state_next = S_FLUSH;
            end
            S_FLUSH: begin
                if (pend_valid) begin
                    if (fo_wen && pend_last)
                        state_next = S_DONE;
                end else if (bitcnt == 6'd0) begin
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_DONE;
            default: state_next = S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= S_RUN;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc        <= '0;
            bitcnt     <= '0;
            pend_data  <= '0;
            pend_valid <= 1'b0;
            pend_last  <= 1'b0;
            fo_cnt     <= '0;
        end else begin
            if (fo_wen) begin
                fo_cnt     <= fo_cnt + 1'b1;
                pend_valid <= 1'b0;
                pend_last  <= 1'b0;
            end
            if (code_ack && width_ok) begin
                bitcnt <= sum[5:0];
                if (sum[6]) begin
                    pend_data  <= merged[127:64];
                    pend_valid <= 1'b1;
                    pend_last  <= 1'b0;
                    acc        <= merged[63:0];
                end else begin
                    acc <= merged[127:64];
                end
            end else if (flush_load) begin
                pend_data  <= acc;
                pend_valid <= 1'b1;
                pend_last  <= 1'b1;
                acc        <= '0;
                bitcnt     <= '0;
            end
        end
    end

endmodule

// File: doc/encode_out.md
ENCODE_OUT -- requirements
Module: encode_out

Interface
REQ-001 Parameter IN_WIDTH, default 13: maximum code width in bits.
REQ-002 Parameter NEED_STR_WIDTH, default 4: width of the code_width field.
REQ-003 Parameter LZF_WIDTH, default 20: width of the word counter.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-low.
REQ-006 code_data  input  IN_WIDTH  code, right-justified; bit [code_width-1] is emitted first.
REQ-007 code_width  input  NEED_STR_WIDTH  number of valid code bits, 1..13.
REQ-008 code_valid  input  1  code_data/code_width are valid.
REQ-009 code_ack  output  1  code accepted this cycle; combinational.
REQ-010 flush  input  1  level; end of stream, pad and emit the partial word.
REQ-011 fo_full  input  1  output FIFO cannot accept a word this cycle.
REQ-012 fo_data  output  64  packed word; first stream bit at bit 63.
REQ-013 fo_wen  output  1  fo_data written to the output FIFO this cycle; combinational.
REQ-014 fo_last  output  1  qualifies fo_wen; final padded word of the stream.
REQ-015 fo_cnt  output  LZF_WIDTH  number of words written since reset.
REQ-016 all_end  output  1  stream fully emitted.

Function
REQ-017 State: acc[63:0] (packed bits, MSB-first), bitcnt[5:0] (0..63), pend_data[63:0], pend_valid, pend_last, FSM {S_RUN, S_FLUSH, S_DONE}.
REQ-018 fo_wen = pend_valid & ~fo_full; fo_data = pend_data; fo_last = pend_last & fo_wen.
REQ-019 code_ack = code_valid & (state==S_RUN) & (~pend_valid | ~fo_full).
REQ-020 On fo_wen: pend_valid clears and fo_cnt increments, wrapping mod 2^LZF_WIDTH, unless the same edge loads a new pending word.
REQ-021 On code_ack with w = code_width, if bitcnt+w < 64: the code is appended at acc[63-bitcnt -: w] and bitcnt += w.
REQ-022 On code_ack with bitcnt+w >= 64: the top 64-bitcnt code bits complete the word into pend_data and pend_valid is set; the remaining bitcnt+w-64 bits are placed at acc[63 -:] with the rest of acc zeroed; bitcnt = bitcnt+w-64.
REQ-023 Latency: a word completed by the code accepted at edge N drives fo_wen in cycle N+1 if fo_full=0, and is held until fo_full=0.
REQ-024 code_width 0 or >13: the code is acked and discarded; acc and bitcnt are unchanged.
REQ-025 S_RUN -> S_FLUSH when flush=1 and code_valid=0; when both are 1, the code is accepted first and flush waits.
REQ-026 In S_FLUSH with pend_valid=1: hold.
REQ-027 In S_FLUSH with pend_valid=0 and bitcnt!=0: load pend_data=acc (zero padded), pend_last=1, bitcnt=0, acc=0, stay; when that word writes -> S_DONE.
REQ-028 In S_FLUSH with pend_valid=0 and bitcnt=0: -> S_DONE with no word emitted.
REQ-029 S_DONE: all_end=1 and code_ack=0 until reset; flush is ignored.
REQ-030 Bits beyond code_width in code_data are ignored; they never reach acc.

Reset
REQ-031 rst=0 asynchronously forces S_RUN and clears acc, bitcnt, pend_data, pend_valid, pend_last, and fo_cnt.
REQ-032 During reset: code_ack=0, fo_wen=0, fo_last=0, fo_data=0, fo_cnt=0, all_end=0.
REQ-033 Reset asserted mid-stream discards partial and pending words; no fo_wen occurs after the edge on which rst=0.

Verification
REQ-034 Five 13-bit codes 0x1FFF, fo_full=0 -> one word 0xFFFFFFFFFFFFFFFF one cycle after the 5th ack, bitcnt=1, fo_cnt=1.
REQ-035 Codes of 9 bits 0x180, then flush, fo_full=0 -> fo_wen with fo_data=0xC000000000000000 and fo_last=1, then all_end=1 and fo_cnt=1.
REQ-036 Word completes while fo_full=1 for 10 cycles -> code_ack=0 throughout, fo_data stable, one fo_wen on the first cycle with fo_full=0, no data loss.
REQ-037 Eight 8-bit codes 0x01..0x08, then flush -> fo_data=0x0102030405060708, fo_last=0; then all_end=1 with no further fo_wen.
REQ-038 rst pulled low after 3 codes with a word pending -> outputs per REQ-032 immediately; a later stream after release packs from bit 63 with fo_cnt starting at 0.
REQ-039 Random widths 1..13 with random fo_full and bits concatenated -> the unpacked output equals the input bit stream exactly, including the padded final word.
